// File: rtl/mp_responder.sv
// Main-memory responder: one fill read or write-back at a time against a 256x8 array.
// Latency: LAT cycles from request acceptance to resp_valid; one request outstanding.
// Backpressure: req_ready is low from acceptance until the response is taken; the response holds until resp_ready.
module mp_responder #(
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wren,
    input  logic [7:0]       req_addr,
    input  logic [7:0]       req_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_wren,
    output logic [7:0]       resp_data,
    output logic [CNT_W-1:0] read_count,
    output logic [CNT_W-1:0] write_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       wren;
        logic [7:0] addr;
        logic [7:0] dat;
    } req_t;

    state_t     state, state_nxt;
    req_t       req_q;
    logic [3:0] lat_cnt;
    logic       done;

    // Contents are stored as data^addr, so zeroed power-up storage reads back as mem[a] = a.
    logic [7:0] mem_q [256];

    assign done = (state == WAIT) && (lat_cnt == 4'd1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 4'd1) state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            req_q       <= '0;
            lat_cnt     <= 4'd0;
            resp_valid  <= 1'b0;
            resp_wren   <= 1'b0;
            resp_data   <= 8'd0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                req_q   <= '{wren: req_wren, addr: req_addr, dat: req_data};
                lat_cnt <= 4'(LAT);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            if (done) begin
                resp_valid <= 1'b1;
                resp_wren  <= req_q.wren;
                if (req_q.wren) begin
                    resp_data <= req_q.dat;
                    if (write_count != '1) write_count <= write_count + CNT_W'(1);
                end else begin
                    resp_data <= mem_q[req_q.addr] ^ req_q.addr;
                    if (read_count != '1) read_count <= read_count + CNT_W'(1);
                end
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // No reset on the array: an async reset forces IDLE, so an interrupted write never lands.
    always_ff @(posedge clock) begin
        if (done && req_q.wren) begin
            mem_q[req_q.addr] <= req_q.dat ^ req_q.addr;
        end
    end

endmodule

// File: tb/tb_mp_responder.sv
// Randomized bench for mp_responder against a plain array/counter model of the memory.
module tb_mp_responder;

    localparam int LAT   = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             resetn;
    logic             req_valid;
    logic             req_ready;
    logic             req_wren;
    logic [7:0]       req_addr;
    logic [7:0]       req_data;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_wren;
    logic [7:0]       resp_data;
    logic [CNT_W-1:0] read_count;
    logic [CNT_W-1:0] write_count;

    mp_responder #(.LAT(LAT), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wren    (req_wren),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_wren   (resp_wren),
        .resp_data   (resp_data),
        .read_count  (read_count),
        .write_count (write_count)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: memory image and completed-operation counts.
    int m_mem [256];
    int m_rd;
    int m_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_rdcnt"}, 32'(read_count), 32'(m_rd));
        check({tag, "_wrcnt"}, 32'(write_count), 32'(m_wr));
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn     = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        m_rd = 0;
        m_wr = 0;
    endtask

    // One full transaction: issue, measure latency, optionally stall the response, consume it.
    task automatic transact(input bit wr, input logic [7:0] a, input logic [7:0] d,
                            input int stall, input bit busy_hold);
        int lat;
        int exp_d;
        @(negedge clock);
        check("idle_rdy", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wren  = wr;
        req_addr  = a;
        req_data  = d;
        exp_d = wr ? int'(d) : m_mem[a];
        @(negedge clock);
        if (busy_hold) begin
            req_wren = 1'b1;
            req_addr = 8'h41;
            req_data = 8'h77;
        end else begin
            req_valid = 1'b0;
        end
        check("busy_rdy", 32'(req_ready), 32'd0);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        req_valid = 1'b0;
        check("latency", 32'(lat), 32'(LAT));
        if (lat >= 40) return;
        if (wr) begin
            m_mem[a] = int'(d);
            if (m_wr < CMAX) m_wr++;
        end else begin
            if (m_rd < CMAX) m_rd++;
        end
        for (int s = 0; s < stall; s++) begin
            check("stall_vld", 32'(resp_valid), 32'd1);
            check("stall_dat", 32'(resp_data), 32'(exp_d));
            check("stall_rdy", 32'(req_ready), 32'd0);
            @(negedge clock);
        end
        check("resp_dat", 32'(resp_data), 32'(exp_d));
        check("resp_wren", 32'(resp_wren), 32'(wr));
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        check("vld_clr", 32'(resp_valid), 32'd0);
        check("rdy_back", 32'(req_ready), 32'd1);
        check_counts("post");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = i;
        m_rd       = 0;
        m_wr       = 0;
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_wren   = 1'b0;
        req_addr   = 8'h00;
        req_data   = 8'h00;
        resp_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_rdy", 32'(req_ready), 32'd1);
        check("rst_vld", 32'(resp_valid), 32'd0);
        check("rst_wren", 32'(resp_wren), 32'd0);
        check("rst_dat", 32'(resp_data), 32'd0);
        check_counts("rst");
        resetn = 1'b1;

        // Fill read, write-back then fill, backpressure, busy request.
        transact(1'b0, 8'h05, 8'h00, 0, 1'b0);
        transact(1'b1, 8'h10, 8'hAB, 0, 1'b0);
        transact(1'b0, 8'h10, 8'h00, 0, 1'b0);
        transact(1'b0, 8'h33, 8'h00, 5, 1'b0);
        do_reset();
        transact(1'b1, 8'h40, 8'h99, 1, 1'b1);
        check("busy_wrcnt", 32'(write_count), 32'd1);
        transact(1'b0, 8'h41, 8'h00, 0, 1'b0);

        // Reset in the middle of a write: no response, no memory update, counters cleared.
        @(negedge clock);
        req_valid = 1'b1;
        req_wren  = 1'b1;
        req_addr  = 8'h20;
        req_data  = 8'hEE;
        @(negedge clock);
        req_valid = 1'b0;
        resetn    = 1'b0;
        #1;
        check("mid_rst_vld", 32'(resp_valid), 32'd0);
        check("mid_rst_rdy", 32'(req_ready), 32'd1);
        m_rd = 0;
        m_wr = 0;
        repeat (3) @(negedge clock);
        check("mid_rst_hold", 32'(resp_valid), 32'd0);
        resetn = 1'b1;
        transact(1'b0, 8'h20, 8'h00, 0, 1'b0);

        // Randomized traffic, biased toward a small address window to exercise read-after-write.
        for (int t = 0; t < 200; t++) begin
            logic [7:0] ra;
            logic [7:0] rd;
            ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            rd = 8'($urandom);
            transact(1'($urandom_range(0, 1)), ra, rd, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end

        // Counter saturation on a fresh reset.
        do_reset();
        for (int k = 0; k < 20; k++) transact(1'b0, 8'($urandom), 8'h00, 0, 1'b0);
        check("sat_rd", 32'(read_count), 32'hF);
        check("sat_wr", 32'(write_count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
